pc_unit: RTL and testbench

- Parametrised program-counter unit for the pipelined MIPS CPU; drives the IF-stage fetch address.
- Adds to a plain PC register: stall hold, buffering of a redirect that arrives during a stall, exception-vector entry, eret return, and a fetch address-error flag.
- Sits between the hazard/branch/CP0 logic and instruction memory.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/pc_unit.sv | 83 ++++++++
 tb/tb_pc_unit.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU constants: PC-unit state encoding, reset/exception vectors and
// the legal text-segment bounds for instruction fetch.
package cpu_pkg;

    typedef enum logic {
        PC_IDLE = 1'b0,
        PC_PEND = 1'b1
    } pc_state_e;

    localparam logic [31:0] RESET_VEC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC   = 32'h0000_4180;
    localparam logic [31:0] TEXT_LO   = 32'h0000_3000;
    localparam logic [31:0] TEXT_HI   = 32'h0000_6FFC;

endpackage

// File: rtl/pc_unit.sv
// IF-stage program counter: stall hold, buffering of a redirect that lands
// during a stall, exception entry, eret return and fetch address-error flag.
module pc_unit
    import cpu_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = cpu_pkg::RESET_VEC,
    parameter logic [ADDR_W-1:0] EXC_VEC   = cpu_pkg::EXC_VEC,
    parameter logic [ADDR_W-1:0] TEXT_LO   = cpu_pkg::TEXT_LO,
    parameter logic [ADDR_W-1:0] TEXT_HI   = cpu_pkg::TEXT_HI
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              stall,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_target,
    input  logic              exc_req,
    input  logic              eret,
    input  logic [ADDR_W-1:0] epc,
    output logic [ADDR_W-1:0] pc,
    output logic [ADDR_W-1:0] pc_plus8,
    output logic              pend_valid,
    output logic              fetch_adel
);

    pc_state_e         r_state;
    pc_state_e         w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_next;
    logic [ADDR_W-1:0] r_pend_target;
    logic [ADDR_W-1:0] w_pend_next;

    // Next-pc priority mux: exception, eret, stall, live redirect, buffered redirect, sequential.
    always_comb begin
        w_pc_next    = r_pc;
        w_state_next = r_state;
        w_pend_next  = r_pend_target;
        if (exc_req) begin
            w_pc_next    = EXC_VEC;
            w_state_next = PC_IDLE;
        end else if (eret) begin
            w_pc_next    = epc;
            w_state_next = PC_IDLE;
        end else if (stall) begin
            // Latest redirect seen during the stall is the one that survives.
            if (redirect_valid) begin
                w_pend_next  = redirect_target;
                w_state_next = PC_PEND;
            end else begin
                w_state_next = r_state;
            end
        end else if (redirect_valid) begin
            w_pc_next    = redirect_target;
            w_state_next = PC_IDLE;
        end else if (r_state == PC_PEND) begin
            w_pc_next    = r_pend_target;
            w_state_next = PC_IDLE;
        end else begin
            w_pc_next    = r_pc + ADDR_W'(4);
            w_state_next = PC_IDLE;
        end
    end

    // State, pc and buffered-target registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc          <= RESET_VEC;
            r_state       <= PC_IDLE;
            r_pend_target <= '0;
        end else begin
            r_pc          <= w_pc_next;
            r_state       <= w_state_next;
            r_pend_target <= w_pend_next;
        end
    end

    assign pc         = r_pc;
    assign pc_plus8   = r_pc + ADDR_W'(8);
    assign pend_valid = (r_state == PC_PEND);
    // Flag only; CP0 decides whether this becomes an exception.
    assign fetch_adel = (r_pc[1:0] != 2'b00) || (r_pc < TEXT_LO) || (r_pc > TEXT_HI);

endmodule

// File: tb/tb_pc_unit.sv
// Directed bench for pc_unit: default instance plus a second instance whose
// text segment extends to the top of the address space.
module tb_pc_unit;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_target;
    logic        exc_req;
    logic        eret;
    logic [31:0] epc;
    logic [31:0] pc, pc_plus8;
    logic        pend_valid, fetch_adel;
    logic [31:0] hi_pc, hi_pc_plus8;
    logic        hi_pend_valid, hi_fetch_adel;

    int n_checks = 0;
    int n_fail   = 0;

    pc_unit u_dut (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(pc), .pc_plus8(pc_plus8), .pend_valid(pend_valid), .fetch_adel(fetch_adel)
    );

    pc_unit #(.TEXT_HI(32'hFFFF_FFFC)) u_dut_hi (
        .clk(clk), .reset(reset), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_target(redirect_target),
        .exc_req(exc_req), .eret(eret), .epc(epc),
        .pc(hi_pc), .pc_plus8(hi_pc_plus8), .pend_valid(hi_pend_valid), .fetch_adel(hi_fetch_adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        exc_req = 1'b0; eret = 1'b0; epc = 32'h0;
        step();
        step();
        reset = 1'b0;
        n_checks++; if (pc !== 32'h0000_3000) begin n_fail++; $display("FAIL reset_pc got %h exp %h", pc, 32'h0000_3000); end
        n_checks++; if (pc_plus8 !== 32'h0000_3008) begin n_fail++; $display("FAIL reset_pc8 got %h exp %h", pc_plus8, 32'h0000_3008); end
        n_checks++; if (fetch_adel !== 1'b0) begin n_fail++; $display("FAIL reset_adel got %b exp 0", fetch_adel); end
        n_checks++; if (pend_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pend got %b exp 0", pend_valid); end
        step();
        n_checks++; if (pc !== 32'h0000_3004) begin n_fail++; $display("FAIL seq1 got %h exp %h", pc, 32'h0000_3004); end
        step();
        n_checks++; if (pc !== 32'h0000_3008) begin n_fail++; $display("FAIL seq2 got %h exp %h", pc, 32'h0000_3008); end
        step();
        n_checks++; if (pc !== 32'h0000_300C) begin n_fail++; $display("FAIL seq3 got %h exp %h", pc, 32'h0000_300C); end
        step();
        n_checks++; if (pc !== 32'h0000_3010) begin n_fail++; $display("FAIL seq4 got %h exp %h", pc, 32'h0000_3010); end
    endtask

    task automatic test_stall_pend();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3100;
        step();
        n_checks++; if (pc !== 32'h0000_3010 || pend_valid !== 1'b1) begin n_fail++; $display("FAIL stall1 got pc=%h pend=%b exp pc=%h pend=1", pc, pend_valid, 32'h0000_3010); end
        redirect_valid = 1'b0;
        step();
        n_checks++; if (pc !== 32'h0000_3010 || pend_valid !== 1'b1) begin n_fail++; $display("FAIL stall2 got pc=%h pend=%b exp pc=%h pend=1", pc, pend_valid, 32'h0000_3010); end
        stall = 1'b0;
        step();
        n_checks++; if (pc !== 32'h0000_3100 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL pend_release got pc=%h pend=%b exp pc=%h pend=0", pc, pend_valid, 32'h0000_3100); end
        step();
        n_checks++; if (pc !== 32'h0000_3104) begin n_fail++; $display("FAIL after_release got %h exp %h", pc, 32'h0000_3104); end
    endtask

    task automatic test_live_beats_pend();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3100;
        step();
        n_checks++; if (pc !== 32'h0000_3104 || pend_valid !== 1'b1) begin n_fail++; $display("FAIL live_setup got pc=%h pend=%b exp pc=%h pend=1", pc, pend_valid, 32'h0000_3104); end
        stall = 1'b0; redirect_target = 32'h0000_3200;
        step();
        n_checks++; if (pc !== 32'h0000_3200 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL live_wins got pc=%h pend=%b exp pc=%h pend=0", pc, pend_valid, 32'h0000_3200); end
        redirect_valid = 1'b0;
        step();
        n_checks++; if (pc !== 32'h0000_3204) begin n_fail++; $display("FAIL live_drop got %h exp %h", pc, 32'h0000_3204); end
    endtask

    task automatic test_exc_eret();
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3300;
        step();
        redirect_valid = 1'b0; exc_req = 1'b1;
        step();
        n_checks++; if (pc !== 32'h0000_4180 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL exc got pc=%h pend=%b exp pc=%h pend=0", pc, pend_valid, 32'h0000_4180); end
        exc_req = 1'b0; stall = 1'b0; eret = 1'b1; epc = 32'h0000_3014;
        step();
        n_checks++; if (pc !== 32'h0000_3014) begin n_fail++; $display("FAIL eret got %h exp %h", pc, 32'h0000_3014); end
        eret = 1'b0;
        step();
        n_checks++; if (pc !== 32'h0000_3018 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL eret_seq got pc=%h pend=%b exp pc=%h pend=0", pc, pend_valid, 32'h0000_3018); end
        exc_req = 1'b1; eret = 1'b1;
        step();
        n_checks++; if (pc !== 32'h0000_4180) begin n_fail++; $display("FAIL exc_over_eret got %h exp %h", pc, 32'h0000_4180); end
        exc_req = 1'b0; eret = 1'b0;
    endtask

    task automatic test_adel();
        redirect_valid = 1'b1; redirect_target = 32'h0000_3102;
        step();
        n_checks++; if (pc !== 32'h0000_3102 || fetch_adel !== 1'b1) begin n_fail++; $display("FAIL adel_misalign got pc=%h adel=%b exp pc=%h adel=1", pc, fetch_adel, 32'h0000_3102); end
        redirect_target = 32'h0000_2FFC;
        step();
        n_checks++; if (pc !== 32'h0000_2FFC || fetch_adel !== 1'b1) begin n_fail++; $display("FAIL adel_low got pc=%h adel=%b exp pc=%h adel=1", pc, fetch_adel, 32'h0000_2FFC); end
        redirect_target = 32'h0000_6FFC;
        step();
        n_checks++; if (pc !== 32'h0000_6FFC || fetch_adel !== 1'b0) begin n_fail++; $display("FAIL adel_hi_edge got pc=%h adel=%b exp pc=%h adel=0", pc, fetch_adel, 32'h0000_6FFC); end
        n_checks++; if (pc_plus8 !== 32'h0000_7004) begin n_fail++; $display("FAIL pc8_hi got %h exp %h", pc_plus8, 32'h0000_7004); end
        redirect_valid = 1'b0;
        step();
        n_checks++; if (pc !== 32'h0000_7000 || fetch_adel !== 1'b1) begin n_fail++; $display("FAIL adel_above got pc=%h adel=%b exp pc=%h adel=1", pc, fetch_adel, 32'h0000_7000); end
    endtask

    task automatic test_wrap_and_reset();
        redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
        step();
        n_checks++; if (hi_pc !== 32'hFFFF_FFFC || hi_fetch_adel !== 1'b0) begin n_fail++; $display("FAIL wrap_top got pc=%h adel=%b exp pc=%h adel=0", hi_pc, hi_fetch_adel, 32'hFFFF_FFFC); end
        n_checks++; if (hi_pc_plus8 !== 32'h0000_0004) begin n_fail++; $display("FAIL wrap_pc8 got %h exp %h", hi_pc_plus8, 32'h0000_0004); end
        n_checks++; if (fetch_adel !== 1'b1) begin n_fail++; $display("FAIL adel_default_top got %b exp 1", fetch_adel); end
        redirect_valid = 1'b0;
        step();
        n_checks++; if (hi_pc !== 32'h0000_0000 || hi_fetch_adel !== 1'b1) begin n_fail++; $display("FAIL wrap_zero got pc=%h adel=%b exp pc=%h adel=1", hi_pc, hi_fetch_adel, 32'h0000_0000); end
        stall = 1'b1; redirect_valid = 1'b1; redirect_target = 32'h0000_3400;
        step();
        n_checks++; if (pend_valid !== 1'b1 || pc !== 32'h0000_0000) begin n_fail++; $display("FAIL rst_setup got pc=%h pend=%b exp pc=%h pend=1", pc, pend_valid, 32'h0000_0000); end
        reset = 1'b1;
        step();
        n_checks++; if (pc !== 32'h0000_3000 || pend_valid !== 1'b0) begin n_fail++; $display("FAIL mid_reset got pc=%h pend=%b exp pc=%h pend=0", pc, pend_valid, 32'h0000_3000); end
        reset = 1'b0; stall = 1'b0; redirect_valid = 1'b0;
        step();
        n_checks++; if (pc !== 32'h0000_3004) begin n_fail++; $display("FAIL post_reset got %h exp %h", pc, 32'h0000_3004); end
    endtask

    initial begin
        test_reset();
        test_stall_pend();
        test_live_beats_pend();
        test_exc_eret();
        test_adel();
        test_wrap_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
